// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-requester round-robin arbiter for a single-port SRAM with read tag return
module sram_rr_arbiter #(
    parameter int WORD_WIDTH = 128,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WORD_WIDTH-1:0] rdata0,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_din,
    input  logic [WORD_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_R0   = 2'd1,
        OWN_R1   = 2'd2
    } own_t;

    own_t                  own_q;
    own_t                  own_d;
    logic                  rr_ptr_q;
    logic                  rr_ptr_d;
    logic                  own_valid;
    logic                  own_id;
    logic                  owner_active;
    logic                  eff_ptr;
    logic                  gnt_any;
    logic                  gnt_sel;
    logic                  gnt_lock;
    logic                  we_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [WORD_WIDTH-1:0] wdata_sel;
    logic                  tag1_valid;
    logic                  tag1_id;
    logic                  tag2_valid;
    logic                  tag2_id;
    logic [WORD_WIDTH-1:0] rdata0_hold;
    logic [WORD_WIDTH-1:0] rdata1_hold;

    // Arbitration state register: lock owner and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            own_q    <= OWN_NONE;
            rr_ptr_q <= 1'b0;
        end else begin
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Grant selection, command mux and next owner/pointer
    always_comb begin
        own_valid    = (own_q != OWN_NONE);
        own_id       = (own_q == OWN_R1);
        owner_active = own_valid && (own_id ? (req1 && lock1) : (req0 && lock0));
        // A released owner hands priority to the other side in the release cycle
        eff_ptr      = (own_valid && !owner_active) ? ~own_id : rr_ptr_q;

        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt_any = 1'b1;
                gnt_sel = owner_active ? own_id : eff_ptr;
            end else if (req0) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end

        gnt_lock  = gnt_sel ? lock1 : lock0;
        we_sel    = gnt_sel ? we1 : we0;
        addr_sel  = gnt_sel ? addr1 : addr0;
        wdata_sel = gnt_sel ? wdata1 : wdata0;

        own_d    = OWN_NONE;
        rr_ptr_d = eff_ptr;
        if (gnt_any) begin
            if (gnt_lock) begin
                // Pointer stays frozen while a burst owner holds the port
                own_d = gnt_sel ? OWN_R1 : OWN_R0;
            end else begin
                rr_ptr_d = ~gnt_sel;
            end
        end

        gnt0 = gnt_any && !gnt_sel;
        gnt1 = gnt_any && gnt_sel;
    end

    // SRAM command register; address and data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
        end else if (gnt_any) begin
            sram_cen  <= 1'b0;
            sram_wen  <= ~we_sel;
            sram_addr <= addr_sel;
            sram_din  <= wdata_sel;
        end else begin
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
        end
    end

    // Two-stage read tag pipeline aligned with the SRAM output register
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_valid <= 1'b0;
            tag1_id    <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_id    <= 1'b0;
        end else begin
            tag1_valid <= gnt_any && !we_sel;
            tag1_id    <= gnt_sel;
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
        end
    end

    assign rvalid0 = tag2_valid && !tag2_id;
    assign rvalid1 = tag2_valid && tag2_id;

    // Capture returned words so an idle requester sees its last read value
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_hold <= '0;
            rdata1_hold <= '0;
        end else begin
            if (rvalid0) rdata0_hold <= sram_q;
            if (rvalid1) rdata1_hold <= sram_q;
        end
    end

    assign rdata0 = rvalid0 ? sram_q : rdata0_hold;
    assign rdata1 = rvalid1 ? sram_q : rdata1_hold;

endmodule
